shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 102 ++++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: an accepted operand is stepped one bit per
// clock in RUN, and the final value is presented with a one-cycle done pulse.
module shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] in,
  input  logic [7:0] shift,
  output logic [7:0] result,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] op_q;
  logic [1:0] op_nx;
  logic [7:0] result_nx;
  logic [7:0] stepped;
  logic [3:0] count;
  logic [3:0] count_nx;
  logic [3:0] eff;

  // Rotates wrap modulo 8; shifts saturate at 8 since further steps change nothing.
  always_comb begin
    eff = 4'd0;
    if (op == OP_ROR)
      eff = {1'b0, shift[2:0]};
    else if (shift >= 8'd8)
      eff = 4'd8;
    else
      eff = shift[3:0];
  end

  always_comb begin
    stepped = result;
    case (op_q)
      OP_SLL:  stepped = {result[6:0], 1'b0};
      OP_SRL:  stepped = {1'b0, result[7:1]};
      OP_SRA:  stepped = {result[7], result[7:1]};
      OP_ROR:  stepped = {result[0], result[7:1]};
      default: stepped = result;
    endcase
  end

  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    result_nx = result;
    count_nx  = count;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          op_nx     = op;
          result_nx = in;
          count_nx  = eff;
          state_nx  = (eff != 4'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        result_nx = stepped;
        count_nx  = (count != 4'd0) ? (count - 4'd1) : 4'd0;
        if (count <= 4'd1)
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_SLL;
      result <= 8'h00;
      count  <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      op_q   <= op_nx;
      result <= result_nx;
      count  <= count_nx;
      busy   <= (state_nx == RUN);
      done   <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer: per-feature tasks with inline checks
// against hand-computed results and cycle counts.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] in;
  logic [7:0] shift;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  shift_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .in     (in),
    .shift  (shift),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one accept, then returns busy-cycle count, cycle index of done,
  // result while done is high, done one cycle later, and any busy/done overlap.
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] s,
                        output int nbusy, output int lat, output logic [7:0] res,
                        output logic done_after, output logic overlap);
    nbusy = 0; lat = -1; res = 8'hxx; done_after = 1'bx; overlap = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; in = a; shift = s;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; in = 8'h00; shift = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if (result !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_result got %h want 00", result); end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags got busy=%b done=%b want 0/0", busy, done); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL release_idle got busy=%b done=%b result=%h want 0/0/00", busy, done, result);
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] s, input logic [7:0] exp_res, input int exp_eff);
    int nb, lat; logic [7:0] r; logic da, ov;
    run_op(o, a, s, nb, lat, r, da, ov);
    tests_run++;
    if (r !== exp_res) begin tests_failed++; $display("[TB] FAIL %s_result got %h want %h", name, r, exp_res); end
    tests_run++;
    if (nb != exp_eff) begin tests_failed++; $display("[TB] FAIL %s_busy got %0d want %0d", name, nb, exp_eff); end
    tests_run++;
    if (lat != exp_eff + 1) begin tests_failed++; $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, exp_eff + 1); end
    tests_run++;
    if (da !== 1'b0 || ov !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_pulse got done_after=%b overlap=%b want 0/0", name, da, ov); end
  endtask

  task automatic test_ror;
    check_op("ror_81_1", 2'b11, 8'h81, 8'd1, 8'hC0, 1);
    check_op("ror_a5_12", 2'b11, 8'hA5, 8'd12, 8'h5A, 4);
    check_op("ror_3c_8", 2'b11, 8'h3C, 8'd8, 8'h3C, 0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (result !== 8'h3C) begin tests_failed++; $display("[TB] FAIL idle_hold got %h want 3C", result); end
  endtask

  task automatic test_shifts;
    check_op("sra_80_3", 2'b10, 8'h80, 8'd3, 8'hF0, 3);
    check_op("sra_80_200", 2'b10, 8'h80, 8'd200, 8'hFF, 8);
    check_op("sll_01_9", 2'b00, 8'h01, 8'd9, 8'h00, 8);
    check_op("sll_01_7", 2'b00, 8'h01, 8'd7, 8'h80, 7);
    check_op("srl_f0_0", 2'b01, 8'hF0, 8'd0, 8'hF0, 0);
    check_op("srl_f0_4", 2'b01, 8'hF0, 8'd4, 8'h0F, 4);
    check_op("sra_7f_2", 2'b10, 8'h7F, 8'd2, 8'h1F, 2);
  endtask

  task automatic test_ignore_start;
    int nb, lat; logic [7:0] r;
    nb = 0; lat = -1; r = 8'hxx;
    @(negedge clk);
    start = 1'b1; op = 2'b00; in = 8'h03; shift = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) begin start = 1'b1; op = 2'b11; in = 8'hFF; shift = 8'd1; end
      if (c == 3) start = 1'b0;
      if (busy) nb++;
      if (done) begin lat = c; r = result; break; end
    end
    start = 1'b0;
    tests_run++;
    if (r !== 8'h30) begin tests_failed++; $display("[TB] FAIL ignore_result got %h want 30", r); end
    tests_run++;
    if (nb != 4 || lat != 5) begin tests_failed++; $display("[TB] FAIL ignore_timing got busy=%0d lat=%0d want 4/5", nb, lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat; logic [7:0] r; logic b_after, d_after;
    lat = -1; r = 8'hxx; b_after = 1'bx; d_after = 1'bx;
    @(negedge clk);
    start = 1'b1; op = 2'b01; in = 8'h80; shift = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        r = result;
        start = 1'b1; op = 2'b00; in = 8'h01; shift = 8'd1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    b_after = busy; d_after = done;
    tests_run++;
    if (r !== 8'h20) begin tests_failed++; $display("[TB] FAIL b2b_first got %h want 20", r); end
    tests_run++;
    if (b_after !== 1'b1 || d_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_bubble got busy=%b done=%b want 1/0", b_after, d_after); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin lat = c; r = result; break; end
    end
    tests_run++;
    if (r !== 8'h02 || lat != 1) begin tests_failed++; $display("[TB] FAIL b2b_second got %h lat=%0d want 02 lat=1", r, lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic saw_done;
    int nb, lat; logic [7:0] r; logic da, ov;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; in = 8'h01; shift = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got result=%h busy=%b done=%b want 00/0/0", result, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_no_done got activity=%b want 0", saw_done); end
    run_op(2'b11, 8'h81, 8'd1, nb, lat, r, da, ov);
    tests_run++;
    if (r !== 8'hC0 || nb != 1 || lat != 2) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_op got %h busy=%0d lat=%0d want C0 1 2", r, nb, lat);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ror();
    test_shifts();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
